// File: rtl/shift_deser_if.sv
// Handshake and serial-side bundle for the shift_deser receiver.
// The master drives the serial strobe and consumer handshake; the slave is the deserializer.
interface shift_deser_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
);
  logic             start;
  logic             dir;
  logic             sdi;
  logic             sdi_en;
  logic             out_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             busy;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  modport master (
    output start, dir, sdi, sdi_en, out_ready, clr_ovr,
    input  data_out, out_valid, busy, bit_cnt, overrun
  );

  modport slave (
    input  start, dir, sdi, sdi_en, out_ready, clr_ovr,
    output data_out, out_valid, busy, bit_cnt, overrun
  );
endinterface

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: gathers WIDTH strobed bits (MSB or LSB first)
// into a word and parks it in a one-entry valid/ready output buffer.
module shift_deser #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        rst,
  shift_deser_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_dir;
  logic             r_valid;
  logic             r_ovr;
  logic             r_busy;

  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_word;
  logic             w_dir;
  logic             w_done;
  logic             w_pop;

  // Shift register contents after accepting sdi; a start discards the partial
  // frame and uses the freshly sampled direction for a same-cycle first bit.
  always_comb begin
    w_base = bus.start ? '0 : r_shreg;
    w_dir  = bus.start ? bus.dir : r_dir;
    if (w_dir) begin
      w_word = {bus.sdi, w_base[WIDTH-1:1]};
    end else begin
      w_word = {w_base[WIDTH-2:0], bus.sdi};
    end
  end

  // Final strobe of a frame (a restart in the same cycle wins), and consumer pop.
  assign w_done = (r_state == SHIFT) && !bus.start && bus.sdi_en &&
                  (r_bit_cnt == CW'(WIDTH - 1));
  assign w_pop  = r_valid && bus.out_ready;

  // Frame FSM: IDLE waits for start, SHIFT accumulates strobed bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_dir     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state   <= SHIFT;
            r_busy    <= 1'b1;
            r_dir     <= bus.dir;
            r_shreg   <= bus.sdi_en ? w_word : '0;
            r_bit_cnt <= bus.sdi_en ? CW'(1) : '0;
          end
        end
        SHIFT: begin
          if (bus.start) begin
            r_dir     <= bus.dir;
            r_shreg   <= bus.sdi_en ? w_word : '0;
            r_bit_cnt <= bus.sdi_en ? CW'(1) : '0;
          end else if (bus.sdi_en) begin
            r_shreg <= w_word;
            if (w_done) begin
              r_state   <= IDLE;
              r_busy    <= 1'b0;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output buffer with sticky overrun on a dropped word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (bus.clr_ovr) begin
        r_ovr <= 1'b0;
      end
      if (w_done) begin
        if (!r_valid || w_pop) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_busy;
  assign bus.bit_cnt   = r_bit_cnt;
  assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_shift_deser.sv
// Scoreboard bench for shift_deser: a bit-queue reference model predicts every
// output; accepted words are queued and checked when the consumer pops them.
module tb_shift_deser;
  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  shift_deser_if #(.WIDTH(W), .CW(CW)) bus ();

  shift_deser #(.WIDTH(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  bit           m_bits[$];
  bit           m_active;
  bit           m_dir;
  logic [W-1:0] m_data;
  bit           m_valid;
  bit           m_ovr;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bits; a full list becomes a word.
  always @(posedge clk) begin
    bit           done;
    bit           pop;
    bit           set_ovr;
    logic [W-1:0] word;
    if (rst) begin
      m_bits.delete();
      m_active = 0; m_dir = 0; m_data = '0; m_valid = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      done = 0; set_ovr = 0; word = '0;
      pop = m_valid && bus.out_ready;
      if (bus.start) begin
        m_active = 1;
        m_dir = bus.dir;
        m_bits.delete();
        if (bus.sdi_en) m_bits.push_back(bus.sdi);
      end else if (m_active && bus.sdi_en) begin
        m_bits.push_back(bus.sdi);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) begin
            if (m_dir) word[i] = m_bits[i];
            else       word[W-1-i] = m_bits[i];
          end
          done = 1;
          m_bits.delete();
          m_active = 0;
        end
      end
      if (done) begin
        if (!m_valid || pop) begin
          m_data = word;
          m_valid = 1;
          exp_q.push_back(word);
        end else begin
          set_ovr = 1;
        end
      end else if (pop) begin
        m_valid = 0;
      end
      if (bus.clr_ovr) m_ovr = 0;
      if (set_ovr) m_ovr = 1;
    end
  end

  // Monitor: compare outputs with the model each cycle; check popped words.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      chk("rst_data_out", 32'(bus.data_out), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
      chk("rst_overrun", 32'(bus.overrun), 32'd0);
    end else begin
      chk("busy", 32'(bus.busy), 32'(m_active));
      chk("bit_cnt", 32'(bus.bit_cnt), 32'(m_bits.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("overrun", 32'(bus.overrun), 32'(m_ovr));
      chk("data_out", 32'(bus.data_out), 32'(m_data));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(bus.data_out), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pop_word", 32'(bus.data_out), 32'(e));
          $display("pop word %02h (expected %02h)", bus.data_out, e);
        end
      end
    end
  end

  task automatic cyc(input logic st, input logic d, input logic s, input logic en,
                     input logic rdy, input logic clr);
    @(posedge clk);
    #2;
    bus.start = st; bus.dir = d; bus.sdi = s; bus.sdi_en = en;
    bus.out_ready = rdy; bus.clr_ovr = clr;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Start pulse, then W strobes; gap idle cycles between strobes.
  task automatic send_word(input logic [W-1:0] word, input logic d, input int gap,
                           input logic last_rdy);
    logic b;
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      b = d ? word[i] : word[W-1-i];
      cyc(1'b0, 1'b0, b, 1'b1, (i == W-1) ? last_rdy : 1'b0, 1'b0);
      if (i != W-1) repeat (gap) idle(1'b0);
    end
    idle(1'b0);
    $display("sent word %02h dir=%0d", word, d);
  endtask

  task automatic expect_now(input string name, input logic [W-1:0] data,
                            input logic valid, input logic ovr);
    @(negedge clk);
    chk({name, "_data"}, 32'(bus.data_out), 32'(data));
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(valid));
    chk({name, "_ovr"}, 32'(bus.overrun), 32'(ovr));
  endtask

  initial begin
    logic [W-1:0] pat;
    bus.start = 0; bus.dir = 0; bus.sdi = 0; bus.sdi_en = 0;
    bus.out_ready = 0; bus.clr_ovr = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    pat = 8'hA5;

    // MSB first, back-to-back strobes
    send_word(pat, 1'b0, 0, 1'b0);
    expect_now("msb_a5", 8'hA5, 1'b1, 1'b0);
    idle(1'b1); idle(1'b0);

    // LSB first, strobe duty 1/3
    send_word(pat, 1'b1, 2, 1'b0);
    expect_now("lsb_gap_a5", 8'hA5, 1'b1, 1'b0);
    idle(1'b1); idle(1'b0);

    // Overrun: second word dropped while the first is unread
    send_word(8'h3C, 1'b0, 0, 1'b0);
    send_word(8'hF0, 1'b0, 0, 1'b0);
    expect_now("overrun", 8'h3C, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    expect_now("clr_ovr", 8'h3C, 1'b1, 1'b0);

    // Completion coincident with pop of the waiting word
    send_word(8'h81, 1'b0, 0, 1'b1);
    expect_now("pop_and_load", 8'h81, 1'b1, 1'b0);
    idle(1'b1); idle(1'b0);

    // Reset mid-frame, then a clean frame
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    bus.sdi_en = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    send_word(8'h5A, 1'b0, 0, 1'b0);
    expect_now("after_rst_5a", 8'h5A, 1'b1, 1'b0);
    idle(1'b1); idle(1'b0);

    // Restart after 3 bits discards the partial frame
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word(8'hC3, 1'b1, 0, 1'b0);
    expect_now("restart_c3", 8'hC3, 1'b1, 1'b0);
    idle(1'b1); idle(1'b0);

    // Randomised traffic, including start with same-cycle strobe
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end
    repeat (4) idle(1'b1);
    idle(1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Receive side of the universal shift register's serial path: reassembles WIDTH bits shifted out of a shift register (left or right) back into a parallel word.
- One-entry output buffer with valid/ready handshake, so the next frame can be shifted in while the previous word waits to be read.
- Sits between a shift register's serial output (SDL/SDR side) and the parallel consumer.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a frame and latches dir.
- dir  input  1  0 = MSB first (left-shift source), 1 = LSB first (right-shift source); sampled only with start.
- sdi  input  1  serial data bit.
- sdi_en  input  1  bit strobe; sdi is captured only on cycles with sdi_en=1.
- out_ready  input  1  consumer accepts data_out.
- clr_ovr  input  1  clears the overrun flag.
- data_out  output  WIDTH  last completed word.
- out_valid  output  1  data_out holds an unread word.
- busy  output  1  a frame is in progress (state SHIFT).
- bit_cnt  output  CW  bits captured in the current frame.
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): state=IDLE, shreg=0, bit_cnt=0, dir_q=0, data_out=0, out_valid=0, overrun=0, busy=0. The partial frame is discarded.
- States: IDLE and SHIFT. busy=1 exactly when state=SHIFT.
- IDLE:
  - start=1 -> SHIFT, dir_q<=dir, shreg<=0, bit_cnt<=0.
  - If sdi_en=1 in the same cycle as start, that bit is captured as the frame's first bit (bit_cnt<=1).
  - sdi_en without start is ignored.
- SHIFT, on each sdi_en=1:
  - dir_q=0: shreg<={shreg[WIDTH-2:0],sdi}.
  - dir_q=1: shreg<={sdi,shreg[WIDTH-1:1]}.
  - bit_cnt<=bit_cnt+1.
- SHIFT, start=1: restarts the frame. Partial bits are discarded, dir is re-latched, and the same-cycle sdi_en rule applies. Restart takes priority over completion.
- Completion: sdi_en=1 with bit_cnt=WIDTH-1 (and no start).
  - The assembled word, including the current bit, is offered to the output buffer.
  - bit_cnt<=0 and state<=IDLE.
  - Latency: data_out and out_valid update on the same edge that samples the final strobe.
- Output buffer:
  - Pop: out_valid=1 and out_ready=1.
  - Completion with out_valid=0: data_out<=word, out_valid<=1.
  - Completion with a simultaneous pop: the new word is loaded and out_valid stays 1. This is not an overrun.
  - Completion with out_valid=1 and no pop: the new word is dropped, data_out is preserved, overrun<=1.
  - Pop without completion: out_valid<=0; data_out holds its last value.
- Overrun: sticky until clr_ovr=1. If clr_ovr and a new overrun occur in the same cycle, set wins.
- out_ready while out_valid=0 has no effect.
- sdi and dir are don't-care when not strobed or sampled.

Test Plan:
- Reset, WIDTH=8, dir=0, start, then sdi_en for 8 consecutive cycles with bits 1,0,1,0,0,1,0,1 -> data_out=8'hA5 and out_valid=1 on the 8th-strobe edge; busy 1->0 at the same edge.
- dir=1 (LSB first), bits 1,0,1,0,0,1,0,1 with idle cycles between strobes (sdi_en duty 1/3) -> data_out=8'hA5 regardless of the gaps; bit_cnt steps 1..7 then 0.
- Word 8'h3C completes with out_ready=0, then word 8'hF0 completes -> data_out stays 8'h3C, overrun=1; clr_ovr -> overrun=0.
- Second completion (8'h81) in the same cycle as a pop of 8'h3C -> data_out=8'h81, out_valid stays 1, overrun stays 0.
- Assert rst after 5 bits have been captured, release, then send 8'h5A MSB first -> data_out=8'h5A, with no residue from the aborted frame; all outputs are 0 while rst=1.
- start re-pulsed after 3 bits with dir=1, then 8 bits of 8'hC3 LSB first -> data_out=8'hC3, earlier bits discarded.
